uart_rx_frame_ctrl: RTL
=======================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Frame-level controller for the UART Rx core; sits beside the Rx bit FSM and Rx shift register in RxCore.
//  Gates the core enable, assembles LSB-first data bits, checks parity/stop, and hands bytes out on valid/ready.
//  Runs a bit-watchdog that force-resets a stalled core and raises sticky error flags for the control register.
// PARAMETERS
//  WDT_WIDTH   8      width of watchdog counter (AcqSig_i ticks)
//  WDT_LIMIT   8'd40  AcqSig_i ticks (16 per bit) allowed between Bit_Synch_i pulses inside a frame
// PORTS
//  clk               in   1  system clock, single domain
//  rst               in   1  asynchronous, active-low reset
//  p_Enable_i        in   1  receiver enable from control register
//  p_ParityEnable_i  in   1  1 = parity bit present
//  p_ParityOdd_i     in   1  1 = odd parity, 0 = even
//  State_i           in   5  Rx FSM one-hot state (INTERVAL,STARTBIT,DATABITS,PARITYBIT,STOPBIT = bit0..4)
//  BitCounter_i      in   4  Rx FSM data-bit index, 0..7
//  Bit_Synch_i       in   1  end-of-bit strobe from shift register
//  BitValue_i        in   1  sampled bit level, valid with Bit_Synch_i
//  AcqSig_i          in   1  16x-baud acquisition strobe
//  ErrClear_i        in   1  1-cycle pulse, clears all sticky flags
//  ByteReady_i       in   1  consumer accepts Byte_o
//  p_CoreEnable_o    out  1  drives Rx FSM p_Enable_i
//  n_CoreRst_o       out  1  active-low soft reset to Rx FSM / shift register
//  Byte_o            out  8  received byte
//  ByteValid_o       out  1  Byte_o valid
//  ParityErr_o  FrameErr_o  Overrun_o  Timeout_o   out 1 each, sticky error flags
//  Busy_o            out  1  frame in progress (ctrl state != IDLE)
// BEHAVIOUR
//  - Reset: ctrl IDLE; p_CoreEnable_o=0, n_CoreRst_o=1, Byte_o=8'h00, ByteValid_o=0, all flags 0, Busy_o=0.
//  - p_CoreEnable_o registered from p_Enable_i (1-cycle lag); deassert mid-frame: current frame still completes and delivers.
//  - Ctrl FSM: IDLE, RECV, CHECK, RECOVER. Ctrl state register triplicated, next state from 2-of-3 majority vote.
//  - IDLE -> RECV when State_i != INTERVAL; clears data shadow, watchdog.
//  - RECV: Bit_Synch_i & DATABITS -> data_r[BitCounter_i] <= BitValue_i; & PARITYBIT -> par_r <= BitValue_i;
//    & STOPBIT -> stop_r <= BitValue_i, go CHECK next cycle.
//  - RECV -> RECOVER if watchdog exceeds WDT_LIMIT, or State_i not one-hot, or State_i==INTERVAL before stop.
//  - Watchdog: +1 per AcqSig_i in RECV, cleared on Bit_Synch_i and in all other states; saturates.
//  - CHECK (1 cycle): perr = p_ParityEnable_i & (^data_r ^ par_r ^ p_ParityOdd_i); ferr = ~stop_r.
//    ferr: byte dropped, FrameErr_o set. else perr: ParityErr_o set, byte still delivered.
//    Delivery: if output slot free or transferring this cycle (ByteValid_o & ByteReady_i) -> load Byte_o, ByteValid_o=1;
//    else Overrun_o set, new byte dropped, old byte kept. -> IDLE.
//  - Latency: stop-bit Bit_Synch_i at cycle N -> CHECK at N+1 -> ByteValid_o high at N+2.
//  - Handshake: transfer on ByteValid_o & ByteReady_i; Byte_o stable while valid & ~ready; valid falls next cycle unless reloaded.
//  - RECOVER: n_CoreRst_o low exactly 2 cycles, Timeout_o set, watchdog cleared -> IDLE; data shadow discarded.
//  - Flags: set on event, cleared by ErrClear_i; set and clear same cycle -> set wins.
//  - Async rst mid-frame: all outputs to reset values immediately, partial byte lost.
// STRUCTURE
//  - uart_pkg: Rx FSM one-hot encodings, ctrl state encodings, WDT_WIDTH/WDT_LIMIT defaults.
//  - Sub-module uart_rx_watchdog: AcqSig_i tick counter with clear, saturate, and expire output.
//  - Top holds ctrl FSM (TMR), data/parity/stop shadow, output slot, flags.
// TESTING
//  1 8N1 byte 0xA5, parity off, ByteReady_i=1 -> Byte_o=0xA5, ByteValid_o 1 cycle at N+2, no flags.
//  2 Even parity on, data 0x03, parity bit 1 -> ParityErr_o=1, Byte_o=0x03 delivered; ErrClear_i pulse -> flag 0.
//  3 Data 0x5A, stop bit 0 -> FrameErr_o=1, ByteValid_o stays 0.
//  4 Bytes 0x11 then 0x22, ByteReady_i=0 -> Byte_o holds 0x11, Overrun_o=1; raise ready -> 0x11 transferred, valid falls.
//  5 Stall Bit_Synch_i in DATABITS for 41 AcqSig_i ticks -> n_CoreRst_o low 2 cycles, Timeout_o=1, Busy_o=0 after.
//  6 Assert rst during DATABITS bit 4 -> all outputs at reset values same cycle; next frame 0x3C received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the UART Rx frame controller.
package uart_pkg;

    localparam int unsigned RX_STATE_W   = 5;
    localparam int unsigned CTRL_STATE_W = 2;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned BIT_IDX_W    = 4;
    localparam int unsigned WDT_WIDTH_DEF = 8;
    localparam logic [7:0]  WDT_LIMIT_DEF = 8'd40;

    // Rx bit FSM one-hot state encodings
    localparam logic [RX_STATE_W-1:0] RX_INTERVAL  = 5'b00001;
    localparam logic [RX_STATE_W-1:0] RX_STARTBIT  = 5'b00010;
    localparam logic [RX_STATE_W-1:0] RX_DATABITS  = 5'b00100;
    localparam logic [RX_STATE_W-1:0] RX_PARITYBIT = 5'b01000;
    localparam logic [RX_STATE_W-1:0] RX_STOPBIT   = 5'b10000;

    // Frame controller state encodings
    localparam logic [CTRL_STATE_W-1:0] CTRL_IDLE    = 2'd0;
    localparam logic [CTRL_STATE_W-1:0] CTRL_RECV    = 2'd1;
    localparam logic [CTRL_STATE_W-1:0] CTRL_CHECK   = 2'd2;
    localparam logic [CTRL_STATE_W-1:0] CTRL_RECOVER = 2'd3;

    typedef struct packed {
        logic parity;
        logic frame;
        logic overrun;
        logic timeout;
    } rx_err_t;

    function automatic logic is_onehot5(input logic [RX_STATE_W-1:0] s);
        return (s != 5'd0) && ((s & (s - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [CTRL_STATE_W-1:0] tmr_vote(
        input logic [CTRL_STATE_W-1:0] a,
        input logic [CTRL_STATE_W-1:0] b,
        input logic [CTRL_STATE_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_watchdog.sv
// Bit watchdog: counts acquisition ticks since the last bit strobe, saturating.
module uart_rx_watchdog
    import uart_pkg::*;
#(
    parameter int unsigned           WDT_WIDTH = WDT_WIDTH_DEF,
    parameter logic [WDT_WIDTH-1:0]  WDT_LIMIT = WDT_WIDTH'(WDT_LIMIT_DEF)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired_c
);

    logic [WDT_WIDTH-1:0] count_r;

    // clear has priority so a tick coinciding with a bit strobe is not counted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (tick && (count_r != '1)) begin
            count_r <= count_r + WDT_WIDTH'(1);
        end
    end

    assign expired_c = (count_r > WDT_LIMIT);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART Rx frame controller: data assembly, parity/stop check, byte handoff,
// watchdog-driven core recovery and sticky error flags.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned           WDT_WIDTH = WDT_WIDTH_DEF,
    parameter logic [WDT_WIDTH-1:0]  WDT_LIMIT = WDT_WIDTH'(WDT_LIMIT_DEF)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   p_Enable_i,
    input  logic                   p_ParityEnable_i,
    input  logic                   p_ParityOdd_i,
    input  logic [RX_STATE_W-1:0]  State_i,
    input  logic [BIT_IDX_W-1:0]   BitCounter_i,
    input  logic                   Bit_Synch_i,
    input  logic                   BitValue_i,
    input  logic                   AcqSig_i,
    input  logic                   ErrClear_i,
    input  logic                   ByteReady_i,
    output logic                   p_CoreEnable_o,
    output logic                   n_CoreRst_o,
    output logic [BYTE_W-1:0]      Byte_o,
    output logic                   ByteValid_o,
    output logic                   ParityErr_o,
    output logic                   FrameErr_o,
    output logic                   Overrun_o,
    output logic                   Timeout_o,
    output logic                   Busy_o
);

    logic [CTRL_STATE_W-1:0] st_a_r, st_b_r, st_c_r;
    logic [CTRL_STATE_W-1:0] st_v, st_nxt;

    logic              core_en_r;
    logic              n_core_rst_r, n_core_rst_nxt;
    logic              busy_r, busy_nxt;
    logic [BYTE_W-1:0] byte_r, byte_nxt;
    logic              byte_valid_r, byte_valid_nxt;
    logic [BYTE_W-1:0] data_r, data_nxt;
    logic              par_r, par_nxt;
    logic              stop_r, stop_nxt;
    logic              rec_cnt_r, rec_cnt_nxt;
    rx_err_t           err_r, err_nxt, err_set;
    logic              perr, ferr, slot_free;
    logic              wdt_clear, wdt_expired_c;

    assign st_v = tmr_vote(st_a_r, st_b_r, st_c_r);

    assign wdt_clear = (st_v != CTRL_RECV) || Bit_Synch_i;

    uart_rx_watchdog #(
        .WDT_WIDTH (WDT_WIDTH),
        .WDT_LIMIT (WDT_LIMIT)
    ) u_wdt (
        .clk       (clk),
        .rst       (rst),
        .clear     (wdt_clear),
        .tick      (AcqSig_i),
        .expired_c (wdt_expired_c)
    );

    // Next-state and next-output logic
    always_comb begin
        st_nxt         = st_v;
        data_nxt       = data_r;
        par_nxt        = par_r;
        stop_nxt       = stop_r;
        rec_cnt_nxt    = 1'b0;
        byte_nxt       = byte_r;
        byte_valid_nxt = byte_valid_r && !ByteReady_i;
        err_set        = '0;
        perr           = 1'b0;
        ferr           = 1'b0;
        slot_free      = !byte_valid_r || ByteReady_i;

        case (st_v)
            CTRL_IDLE: begin
                if (State_i != RX_INTERVAL) begin
                    st_nxt   = CTRL_RECV;
                    data_nxt = '0;
                    par_nxt  = 1'b0;
                    stop_nxt = 1'b0;
                end
            end
            CTRL_RECV: begin
                if (Bit_Synch_i && (State_i == RX_DATABITS) && !BitCounter_i[3]) begin
                    data_nxt[BitCounter_i[2:0]] = BitValue_i;
                end
                if (Bit_Synch_i && (State_i == RX_PARITYBIT)) begin
                    par_nxt = BitValue_i;
                end
                // a completed stop bit takes precedence over any stall indication
                if (Bit_Synch_i && (State_i == RX_STOPBIT)) begin
                    stop_nxt = BitValue_i;
                    st_nxt   = CTRL_CHECK;
                end else if (wdt_expired_c || !is_onehot5(State_i) ||
                             (State_i == RX_INTERVAL)) begin
                    st_nxt          = CTRL_RECOVER;
                    err_set.timeout = 1'b1;
                end
            end
            CTRL_CHECK: begin
                perr = p_ParityEnable_i && (^data_r ^ par_r ^ p_ParityOdd_i);
                ferr = !stop_r;
                if (ferr) begin
                    err_set.frame = 1'b1;
                end else begin
                    err_set.parity = perr;
                    if (slot_free) begin
                        byte_nxt       = data_r;
                        byte_valid_nxt = 1'b1;
                    end else begin
                        err_set.overrun = 1'b1;
                    end
                end
                st_nxt = CTRL_IDLE;
            end
            CTRL_RECOVER: begin
                data_nxt    = '0;
                par_nxt     = 1'b0;
                stop_nxt    = 1'b0;
                rec_cnt_nxt = 1'b1;
                if (rec_cnt_r) begin
                    st_nxt = CTRL_IDLE;
                end
            end
            default: begin
                st_nxt = CTRL_IDLE;
            end
        endcase

        n_core_rst_nxt = (st_nxt != CTRL_RECOVER);
        busy_nxt       = (st_nxt != CTRL_IDLE);
        err_nxt        = rx_err_t'(err_set | (err_r & ~{4{ErrClear_i}}));
    end

    // Triplicated state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_a_r       <= CTRL_IDLE;
            st_b_r       <= CTRL_IDLE;
            st_c_r       <= CTRL_IDLE;
            core_en_r    <= 1'b0;
            n_core_rst_r <= 1'b1;
            busy_r       <= 1'b0;
            byte_r       <= '0;
            byte_valid_r <= 1'b0;
            data_r       <= '0;
            par_r        <= 1'b0;
            stop_r       <= 1'b0;
            rec_cnt_r    <= 1'b0;
            err_r        <= '0;
        end else begin
            st_a_r       <= st_nxt;
            st_b_r       <= st_nxt;
            st_c_r       <= st_nxt;
            core_en_r    <= p_Enable_i;
            n_core_rst_r <= n_core_rst_nxt;
            busy_r       <= busy_nxt;
            byte_r       <= byte_nxt;
            byte_valid_r <= byte_valid_nxt;
            data_r       <= data_nxt;
            par_r        <= par_nxt;
            stop_r       <= stop_nxt;
            rec_cnt_r    <= rec_cnt_nxt;
            err_r        <= err_nxt;
        end
    end

    assign p_CoreEnable_o = core_en_r;
    assign n_CoreRst_o    = n_core_rst_r;
    assign Byte_o         = byte_r;
    assign ByteValid_o    = byte_valid_r;
    assign ParityErr_o    = err_r.parity;
    assign FrameErr_o     = err_r.frame;
    assign Overrun_o      = err_r.overrun;
    assign Timeout_o      = err_r.timeout;
    assign Busy_o         = busy_r;

endmodule
